// File: rtl/countdown_timer_ctrl.sv
// mm:ss countdown controller driven by a 1 Hz tick; BCD count registers feed the display directly.
// Commands are one-cycle pulses. The divider is cleared on every entry into RUN.
module countdown_timer_ctrl #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic       div_clr,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] MAX_TENS  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MAX_MIN % 10);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] cnt_load, cnt_dec;
  logic [3:0]  lm_t, lm_u, ls_t, ls_u;
  logic        tick_eff, div_clr_n, done_n;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Load path: saturate each digit first, then the whole field.
  always_comb begin
    lm_t = sat9(load_min[7:4]);
    lm_u = sat9(load_min[3:0]);
    ls_t = sat9(load_sec[7:4]);
    ls_u = sat9(load_sec[3:0]);
    cnt_load = {lm_t, lm_u, ls_t, ls_u};
    if (lm_t > MAX_TENS || (lm_t == MAX_TENS && lm_u > MAX_UNITS))
      cnt_load[15:8] = {MAX_TENS, MAX_UNITS};
    if (ls_t > 4'd5)
      cnt_load[7:0] = 8'h59;
  end

  // One-second BCD decrement with borrow from minutes.
  always_comb begin
    cnt_dec = cnt;
    if (cnt[7:0] != 8'h00) begin
      if (cnt[3:0] != 4'd0) cnt_dec[3:0] = cnt[3:0] - 4'd1;
      else                  cnt_dec[7:0] = {cnt[7:4] - 4'd1, 4'd9};
    end else begin
      cnt_dec[7:0] = 8'h59;
      if (cnt[11:8] != 4'd0) cnt_dec[11:8]  = cnt[11:8] - 4'd1;
      else                   cnt_dec[15:8] = {cnt[15:12] - 4'd1, 4'd9};
    end
  end

  // A tick landing while the divider is being cleared belongs to the old second.
  assign tick_eff = tick_1s & ~div_clr;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (load) cnt_n = cnt_load;
        else if (start && cnt != 16'h0000) state_n = RUN;
      end
      RUN: begin
        if (tick_eff) begin
          // A zero count here (started from PAUSED at 00:00) expires without underflowing.
          if (cnt == 16'h0000) begin
            state_n = EXPIRED;
          end else begin
            cnt_n = cnt_dec;
            if (cnt_dec == 16'h0000) state_n = EXPIRED;
            else if (pause)          state_n = PAUSED;
          end
        end else if (pause) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (load)       cnt_n = cnt_load;
        else if (start) state_n = RUN;
      end
      EXPIRED: begin
        if (load) begin
          cnt_n   = cnt_load;
          state_n = IDLE;
        end else if (start || pause) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    div_clr_n = (state != RUN) && (state_n == RUN);
    done_n    = (state == RUN) && (state_n == EXPIRED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 16'h0000;
      div_clr <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_clr <= div_clr_n;
      done    <= done_n;
      running <= (state_n == RUN);
      alarm   <= (state_n == EXPIRED);
    end
  end

  assign min_bcd   = cnt[15:8];
  assign sec_bcd   = cnt[7:0];
  assign state_dbg = state;

endmodule
